stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
- Memory stage between execute and write.
- Takes one ALU result or load/store per handshake from execute and runs the data-memory transaction over a req/ack bus.
- Aligns and sign-extends load data, then presents a registered writeback record (wb_valid/wb_pc/wb_reg/wb_data) to stage_write, honouring wb_stall.
- Flags misaligned accesses and bus timeouts as exceptions instead of writing back.

Parameters:
TIMEOUT, 0, cycles dmem_req may stay unacknowledged before a bus-error exception; 0 disables the timeout counter.

Ports:
clk  in  1  clock; all state on posedge.
reset_n  in  1  asynchronous active-low reset.
mem_valid  in  1  execute presents an instruction.
mem_pc  in  32  instruction PC.
mem_ls  in  2  0 none, 1 load, 2 store (3 treated as none).
mem_funct3  in  3  RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
mem_addr  in  32  ALU result / effective address.
mem_wdata  in  32  store data (rs2).
mem_reg  in  5  destination register.
mem_stall  out  1  execute must hold its outputs.
dmem_req  out  1  data-memory request.
dmem_we  out  1  1 store, 0 load.
dmem_addr  out  32  {mem_addr[31:2],2'b00}.
dmem_be  out  4  byte enables.
dmem_wdata  out  32  store data replicated into lanes.
dmem_ack  in  1  request completes this cycle; rdata valid for loads.
dmem_rdata  in  32  load word.
wb_valid  out  1  writeback record valid.
wb_pc  out  32  retiring PC.
wb_reg  out  5  destination (0 for stores).
wb_data  out  32  result.
wb_stall  in  1  write stage cannot accept.
exc_valid  out  1  one-cycle exception pulse.
exc_pc  out  32  faulting PC.
exc_cause  out  2  0 load misaligned, 1 store misaligned, 2 bus timeout.

Behaviour:
- Reset (async, reset_n=0): state IDLE; S_valid=0; wb_valid=0; wb_pc/wb_reg/wb_data=0; dmem_req=0; exc_valid=0; exc_pc=0; exc_cause=0; timeout counter=0.
- Two registers: S (captured instruction) and W (wb_* outputs).
- Accept: mem_valid && !mem_stall captures inputs into S at the edge.
- mem_stall = S_valid && !S_adv.
- Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. Evaluated at capture.
- FSM:
  - IDLE: on accept go to ISSUE if ls is load/store and aligned, else DONE.
  - ISSUE: dmem_req=1 with fields stable. On dmem_ack, latch the aligned result and go to DONE; an ack in the first ISSUE cycle is legal. On timeout (counter reaches TIMEOUT-1 without ack, TIMEOUT>0), drop req and raise exception.
  - DONE: wait for W slot.
- w_free = !wb_valid || !wb_stall.
- S_adv = (DONE or ack this cycle) && w_free, or exception this cycle. On S_adv: W loads S unless exception; S reloads if a new accept occurs the same edge (back-to-back, no bubble); else go to IDLE.
- W: when w_free and nothing loads, wb_valid drops to 0. If wb_stall=1, W holds all fields.
- Exceptions (misaligned or timeout): exc_valid=1 for exactly one cycle, in the cycle after capture (misaligned) or after the timeout. Nothing is written back, no dmem_req is issued for a misaligned access, and S frees.
- ALU op: wb_data=mem_addr. Latency accept to wb_valid is 1 edge.
- Load data: shift dmem_rdata right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W as is. Latency is 1 edge after the ack edge.
- Store:
  - be: B=0001<<addr[1:0]; H=0011<<addr[1:0]; W=1111.
  - wdata: B={4{d[7:0]}}, H={2{d[15:0]}}, W=d.
  - wb_valid=1, wb_reg=0, wb_data=0, so the write stage retires the store.
- dmem_ack outside ISSUE is ignored, including a stale ack after reset mid-transaction.

Decomposition:
- Package riscv_mem_pkg: ls encodings, funct3 width codes, exc_cause codes, FSM state enum.
- One combinational sub-module mem_align: funct3, addr[1:0], store data, rdata -> be, replicated wdata, extended load data, misaligned flag.

Test Plan:
- ALU op pc=0x100, addr=0xDEADBEEF, reg=5 -> next edge wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF; no dmem_req.
- LB addr=0x1003, rdata=0x80FF7F01, ack 2 cycles late -> dmem_addr=0x1000, dmem_we=0, mem_stall high until ack; wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr=0x2002, wdata=0x1234ABCD, ack same cycle -> be=1100, dmem_wdata=0xABCDABCD, wb_reg=0.
- LW addr=0x3001 -> no dmem_req, exc_valid pulse with cause 0, exc_pc=pc, no wb_valid.
- TIMEOUT=4, no ack -> req for 4 cycles, then req=0, exc cause 2; wb_stall=1 for 3 cycles with W full -> wb_* held, mem_stall=1.
- reset_n low while in ISSUE -> all outputs 0 immediately; ack arriving after release causes no wb_valid.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory stage:
// access kinds, funct3 widths, exception causes, FSM states.
package riscv_mem_pkg;

    localparam logic [1:0] LS_NONE  = 2'd0;
    localparam logic [1:0] LS_LOAD  = 2'd1;
    localparam logic [1:0] LS_STORE = 2'd2;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] CAUSE_LD_MIS = 2'd0;
    localparam logic [1:0] CAUSE_ST_MIS = 2'd1;
    localparam logic [1:0] CAUSE_BUS    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // funct3[1:0]: 00 byte, 01 half, else word
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and
// alignment/extension for loads.
module mem_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic [31:0] ld_data,
    output logic        mis
);

    logic [31:0] sh;
    logic        uns;

    // lane enables, replicated store data, extended load data
    always_comb begin
        sh        = rdata >> {addr, 3'b000};
        uns       = funct3[2];
        be        = 4'b1111;
        lane_data = st_data;
        ld_data   = sh;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr;
                lane_data = {4{st_data[7:0]}};
                ld_data   = {{24{sh[7] & ~uns}}, sh[7:0]};
            end
            2'b01: begin
                be        = 4'b0011 << addr;
                lane_data = {2{st_data[15:0]}};
                ld_data   = {{16{sh[15] & ~uns}}, sh[15:0]};
            end
            default: begin
                be        = 4'b1111;
                lane_data = st_data;
                ld_data   = sh;
            end
        endcase
        mis = misaligned(funct3, addr);
    end

endmodule

// File: rtl/stage_mem.sv
// Memory stage: runs one load/store per instruction
// over req/ack and hands a writeback record onward.
module stage_mem
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [1:0]  mem_ls,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    input  logic        wb_stall,
    output logic        exc_valid,
    output logic [31:0] exc_pc,
    output logic [1:0]  exc_cause
);

    state_t      state, state_nx, target;
    logic [31:0] s_pc, s_addr, s_wdata, s_res, cnt;
    logic [1:0]  s_ls, s_cause;
    logic [2:0]  s_funct3;
    logic [4:0]  s_reg;
    logic        s_exc;

    logic        s_valid, ack_now, exc_now, timeout_hit;
    logic        w_free, s_adv, accept;
    logic        in_ldst, in_mis, s_load;
    logic [3:0]  al_be;
    logic [31:0] al_lane, al_ld;
    logic        al_mis;

    mem_align u_align (
        .funct3    (s_funct3),
        .addr      (s_addr[1:0]),
        .st_data   (s_wdata),
        .rdata     (dmem_rdata),
        .be        (al_be),
        .lane_data (al_lane),
        .ld_data   (al_ld),
        .mis       (al_mis)
    );

    assign s_valid     = (state != ST_IDLE);
    assign s_load      = (s_ls == LS_LOAD);
    assign ack_now     = (state == ST_ISSUE) && dmem_ack;
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_ISSUE)
                         && !dmem_ack && (cnt == TIMEOUT - 1);
    assign exc_now     = (state == ST_DONE) && s_exc;
    assign w_free      = !wb_valid || !wb_stall;
    assign s_adv       = exc_now ||
                         ((((state == ST_DONE) && !s_exc) || ack_now)
                          && w_free);
    assign mem_stall   = s_valid && !s_adv;
    assign accept      = mem_valid && !mem_stall;
    assign in_ldst     = (mem_ls == LS_LOAD) || (mem_ls == LS_STORE);
    assign in_mis      = in_ldst && misaligned(mem_funct3, mem_addr[1:0]);
    assign target      = (in_ldst && !in_mis) ? ST_ISSUE : ST_DONE;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // next state: capture, bus completion, timeout, release
    always_comb begin
        state_nx = state;
        if (state == ST_IDLE) begin
            if (accept) state_nx = target;
        end else if (s_adv) begin
            state_nx = accept ? target : ST_IDLE;
        end else if (ack_now || timeout_hit) begin
            state_nx = ST_DONE;
        end
    end

    // bus and exception outputs, quiet outside their states
    always_comb begin
        dmem_req   = (state == ST_ISSUE) && !al_mis;
        dmem_we    = dmem_req && (s_ls == LS_STORE);
        dmem_addr  = dmem_req ? {s_addr[31:2], 2'b00} : 32'h0;
        dmem_be    = dmem_req ? al_be : 4'h0;
        dmem_wdata = dmem_req ? al_lane : 32'h0;
        exc_valid  = exc_now;
        exc_pc     = exc_now ? s_pc : 32'h0;
        exc_cause  = exc_now ? s_cause : 2'd0;
    end

    // S: captured instruction plus partial result and fault info
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_pc     <= '0;
            s_ls     <= '0;
            s_funct3 <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_reg    <= '0;
            s_res    <= '0;
            s_exc    <= 1'b0;
            s_cause  <= '0;
        end else if (accept) begin
            s_pc     <= mem_pc;
            s_ls     <= mem_ls;
            s_funct3 <= mem_funct3;
            s_addr   <= mem_addr;
            s_wdata  <= mem_wdata;
            s_reg    <= (mem_ls == LS_STORE) ? 5'd0 : mem_reg;
            s_res    <= in_ldst ? 32'h0 : mem_addr;
            s_exc    <= in_mis;
            s_cause  <= (mem_ls == LS_STORE) ? CAUSE_ST_MIS
                                              : CAUSE_LD_MIS;
        end else if (ack_now) begin
            if (s_load) s_res <= al_ld;
        end else if (timeout_hit) begin
            s_exc   <= 1'b1;
            s_cause <= CAUSE_BUS;
        end
    end

    // cycles spent waiting for ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                cnt <= '0;
        else if (accept)             cnt <= '0;
        else if (state == ST_ISSUE)  cnt <= cnt + 32'd1;
    end

    // W: writeback record, held while the write stage stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_pc    <= '0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else if (s_adv && !exc_now) begin
            wb_valid <= 1'b1;
            wb_pc    <= s_pc;
            wb_reg   <= s_reg;
            wb_data  <= (ack_now && s_load) ? al_ld : s_res;
        end else if (w_free) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: vector table for
// single accesses plus timeout/stall/reset sequences.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [1:0]  mem_ls;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_reg;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [1:0]  exc_cause;

    int errors = 0;
    int checks = 0;

    stage_mem #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_ls     (mem_ls),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_reg    (mem_reg),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .exc_valid  (exc_valid),
        .exc_pc     (exc_pc),
        .exc_cause  (exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ls;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          dly;
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] lane;
        logic [4:0]  wreg;
        logic [31:0] wdat;
        logic        exc;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] ls, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        mem_valid  = 1'b1;
        mem_ls     = ls;
        mem_funct3 = f3;
        mem_pc     = pc;
        mem_addr   = addr;
        mem_wdata  = wd;
        mem_reg    = rd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string n;
        n = $sformatf("v%0d", idx);
        present(v.ls, v.f3, v.pc, v.addr, v.wdata, v.rd);
        #1;
        chk({n, ".accept_stall"}, 32'(mem_stall), 32'd0);
        step();
        mem_valid = 1'b0;
        #1;
        if (v.exc) begin
            chk({n, ".exc_valid"}, 32'(exc_valid), 32'd1);
            chk({n, ".exc_cause"}, 32'(exc_cause), 32'(v.cause));
            chk({n, ".exc_pc"}, exc_pc, v.pc);
            chk({n, ".no_req"}, 32'(dmem_req), 32'd0);
            step();
            chk({n, ".exc_done"}, 32'(exc_valid), 32'd0);
            chk({n, ".no_wb"}, 32'(wb_valid), 32'd0);
        end else if (v.ls == 2'd1 || v.ls == 2'd2) begin
            chk({n, ".req"}, 32'(dmem_req), 32'd1);
            chk({n, ".daddr"}, dmem_addr, v.daddr);
            chk({n, ".we"}, 32'(dmem_we), 32'(v.ls == 2'd2));
            chk({n, ".be"}, 32'(dmem_be), 32'(v.be));
            chk({n, ".lane"}, dmem_wdata, v.lane);
            for (int i = 0; i < v.dly; i++) begin
                chk({n, ".wait_stall"}, 32'(mem_stall), 32'd1);
                step();
                chk({n, ".wait_req"}, 32'(dmem_req), 32'd1);
            end
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            chk({n, ".ack_stall"}, 32'(mem_stall), 32'd0);
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h0;
            #1;
            chk({n, ".wb_valid"}, 32'(wb_valid), 32'd1);
            chk({n, ".wb_pc"}, wb_pc, v.pc);
            chk({n, ".wb_reg"}, 32'(wb_reg), 32'(v.wreg));
            chk({n, ".wb_data"}, wb_data, v.wdat);
            chk({n, ".req_drop"}, 32'(dmem_req), 32'd0);
        end else begin
            chk({n, ".alu_no_req"}, 32'(dmem_req), 32'd0);
            step();
            chk({n, ".wb_valid"}, 32'(wb_valid), 32'd1);
            chk({n, ".wb_pc"}, wb_pc, v.pc);
            chk({n, ".wb_reg"}, 32'(wb_reg), 32'(v.wreg));
            chk({n, ".wb_data"}, wb_data, v.wdat);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ls f3 pc addr wdata rdata rd dly daddr be lane wreg wdat exc cause
        vecs[0]  = '{2'd0, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5,
                     0, 32'h0, 4'h0, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0};
        vecs[1]  = '{2'd1, 3'd0, 32'h104, 32'h1003, 32'h0, 32'h80FF7F01,
                     5'd7, 2, 32'h1000, 4'b1000, 32'h0, 5'd7, 32'hFFFFFF80,
                     1'b0, 2'd0};
        vecs[2]  = '{2'd1, 3'd4, 32'h108, 32'h1003, 32'h0, 32'h80FF7F01,
                     5'd7, 2, 32'h1000, 4'b1000, 32'h0, 5'd7, 32'h00000080,
                     1'b0, 2'd0};
        vecs[3]  = '{2'd2, 3'd1, 32'h10C, 32'h2002, 32'h1234ABCD, 32'h0,
                     5'd9, 0, 32'h2000, 4'b1100, 32'hABCDABCD, 5'd0, 32'h0,
                     1'b0, 2'd0};
        vecs[4]  = '{2'd1, 3'd2, 32'h110, 32'h3001, 32'h0, 32'h0, 5'd4,
                     0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0, 1'b1, 2'd0};
        vecs[5]  = '{2'd1, 3'd1, 32'h114, 32'h4002, 32'h0, 32'h80011234,
                     5'd6, 1, 32'h4000, 4'b1100, 32'h0, 5'd6, 32'hFFFF8001,
                     1'b0, 2'd0};
        vecs[6]  = '{2'd1, 3'd5, 32'h118, 32'h4000, 32'h0, 32'h0000F00D,
                     5'd8, 0, 32'h4000, 4'b0011, 32'h0, 5'd8, 32'h0000F00D,
                     1'b0, 2'd0};
        vecs[7]  = '{2'd2, 3'd2, 32'h11C, 32'h5001, 32'h55, 32'h0, 5'd2,
                     0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0, 1'b1, 2'd1};
        vecs[8]  = '{2'd2, 3'd0, 32'h120, 32'h6001, 32'h000000A5, 32'h0,
                     5'd3, 1, 32'h6000, 4'b0010, 32'hA5A5A5A5, 5'd0, 32'h0,
                     1'b0, 2'd0};
        vecs[9]  = '{2'd1, 3'd2, 32'h124, 32'h7004, 32'h0, 32'hCAFEBABE,
                     5'd31, 3, 32'h7004, 4'b1111, 32'h0, 5'd31, 32'hCAFEBABE,
                     1'b0, 2'd0};
        vecs[10] = '{2'd3, 3'd2, 32'h128, 32'h00ABCDEF, 32'h0, 32'h0,
                     5'd1, 0, 32'h0, 4'h0, 32'h0, 5'd1, 32'h00ABCDEF,
                     1'b0, 2'd0};
        vecs[11] = '{2'd2, 3'd1, 32'h12C, 32'h2001, 32'h0, 32'h0, 5'd2,
                     0, 32'h0, 4'h0, 32'h0, 5'd0, 32'h0, 1'b1, 2'd1};

        reset_n    = 1'b0;
        mem_valid  = 1'b0;
        mem_pc     = 32'h0;
        mem_ls     = 2'd0;
        mem_funct3 = 3'd0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_reg    = 5'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        wb_stall   = 1'b0;
        #12;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_pc", wb_pc, 32'h0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.exc_valid", 32'(exc_valid), 32'd0);
        chk("rst.mem_stall", 32'(mem_stall), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // bus timeout: four request cycles then a cause-2 pulse
        present(2'd1, 3'd2, 32'h300, 32'h8000, 32'h0, 5'd10);
        step();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.req%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("to.noexc%0d", i), 32'(exc_valid), 32'd0);
            step();
        end
        chk("to.req_drop", 32'(dmem_req), 32'd0);
        chk("to.exc_valid", 32'(exc_valid), 32'd1);
        chk("to.exc_cause", 32'(exc_cause), 32'd2);
        chk("to.exc_pc", exc_pc, 32'h300);
        step();
        chk("to.exc_once", 32'(exc_valid), 32'd0);
        chk("to.no_wb", 32'(wb_valid), 32'd0);

        // back-to-back ALU ops with the write stage stalling
        present(2'd0, 3'd0, 32'h200, 32'h11, 32'h0, 5'd3);
        step();
        present(2'd0, 3'd0, 32'h204, 32'h22, 32'h0, 5'd4);
        #1;
        chk("bb.no_bubble", 32'(mem_stall), 32'd0);
        step();
        wb_stall = 1'b1;
        present(2'd0, 3'd0, 32'h208, 32'h33, 32'h0, 5'd5);
        #1;
        chk("bb.wbA_valid", 32'(wb_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("st.stall%0d", i), 32'(mem_stall), 32'd1);
            chk($sformatf("st.pc%0d", i), wb_pc, 32'h200);
            chk($sformatf("st.data%0d", i), wb_data, 32'h11);
            step();
        end
        chk("st.held_reg", 32'(wb_reg), 32'd3);
        wb_stall = 1'b0;
        #1;
        chk("st.release", 32'(mem_stall), 32'd0);
        step();
        mem_valid = 1'b0;
        chk("bb.wbB_pc", wb_pc, 32'h204);
        chk("bb.wbB_data", wb_data, 32'h22);
        step();
        chk("bb.wbC_pc", wb_pc, 32'h208);
        chk("bb.wbC_reg", 32'(wb_reg), 32'd5);

        // reset mid-transaction, then a stale ack
        wb_stall = 1'b1;
        present(2'd1, 3'd2, 32'h400, 32'h9000, 32'h0, 5'd12);
        step();
        mem_valid = 1'b0;
        chk("rm.req", 32'(dmem_req), 32'd1);
        chk("rm.wb_held", 32'(wb_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rm.req0", 32'(dmem_req), 32'd0);
        chk("rm.be0", 32'(dmem_be), 32'd0);
        chk("rm.wb0", 32'(wb_valid), 32'd0);
        chk("rm.wbpc0", wb_pc, 32'h0);
        chk("rm.stall0", 32'(mem_stall), 32'd0);
        wb_stall = 1'b0;
        #2;
        reset_n = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        chk("rm.stale_wb", 32'(wb_valid), 32'd0);
        step();
        chk("rm.stale_wb2", 32'(wb_valid), 32'd0);
        chk("rm.stale_req", 32'(dmem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
